// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Vector sequencer feeding one SIMD ALU lane. Accepts one command at a time.
// It streams A/B operands out of 1-cycle-latency BRAMs, one element per clock,
// onto the ALU inputs. The registered ALU result is then either written to the
// result BRAM element by element or summed into a single DOTP word.
//
// Element pipeline (read issued in cycle t):
//   t    mem_*_addr = base + i
//   t+1  BRAM data presented straight to alu_a/alu_b with the command opcode
//   t+2  alu_out valid: written out (ADD/SUB/MUL) or accumulated (DOTP)

module alu_issue_ctrl #(
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_W       = 10,
  parameter int LEN_W        = 11
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [ADDR_W-1:0]       cmd_a_base,
  input  logic [ADDR_W-1:0]       cmd_b_base,
  input  logic [ADDR_W-1:0]       cmd_d_base,

  output logic [ADDR_W-1:0]       mem_a_addr,
  input  logic [31:0]             mem_a_data,
  output logic [ADDR_W-1:0]       mem_b_addr,
  input  logic [31:0]             mem_b_data,

  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [31:0]             alu_out,

  output logic                    res_we,
  output logic [ADDR_W-1:0]       res_addr,
  output logic [31:0]             res_data,

  output logic                    busy,
  output logic                    done,
  output logic                    halted,
  output logic                    err
);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOOP = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_DOTP = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_STOP = OPCODE_WIDTH'(8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        rd_cnt;     // reads issued so far, including the current one
  logic [ADDR_W-1:0]       d_base_q;
  logic [ADDR_W-1:0]       wr_addr;    // destination of the next element result
  logic [31:0]             acc;
  logic                    acc_wr;     // DOTP final write happens this cycle
  logic                    v1;         // element sitting on the ALU inputs
  logic                    v2;         // ALU result valid this cycle

  logic accept;
  logic cmd_is_vec;
  logic cmd_is_bad;
  logic op_is_dotp;

  // Command decode and handshake; reset forces cmd_ready low even in IDLE.
  assign cmd_ready  = rstn & (state == S_IDLE) & ~halted;
  assign accept     = cmd_valid & cmd_ready;
  assign cmd_is_vec = (cmd_opcode >= OP_ADD) && (cmd_opcode <= OP_DOTP);
  assign cmd_is_bad = (cmd_opcode > OP_DOTP) && (cmd_opcode != OP_STOP);
  assign op_is_dotp = (op_q == OP_DOTP);

  // BRAM data goes to the ALU in the cycle it arrives; without a valid
  // element the ALU sees NOOP and zero operands, so its output idles at 0.
  assign alu_a      = v1 ? mem_a_data : '0;
  assign alu_b      = v1 ? mem_b_data : '0;
  assign alu_opcode = v1 ? op_q : OP_NOOP;

  // Result port: per-element writes for ADD/SUB/MUL, one final word for DOTP.
  assign res_we   = rstn & ((v2 & ~op_is_dotp) | acc_wr);
  assign res_addr = acc_wr ? d_base_q : wr_addr;
  assign res_data = acc_wr ? acc : alu_out;

  // Sequencer FSM, read-address generation and result accumulation.
  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values; the reset is synchronous, checked inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      op_q       <= OP_NOOP;
      len_q      <= '0;
      rd_cnt     <= '0;
      d_base_q   <= '0;
      wr_addr    <= '0;
      acc        <= '0;
      acc_wr     <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      mem_a_addr <= '0;
      mem_b_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      v1     <= (state == S_RUN);
      v2     <= v1;
      done   <= 1'b0;
      err    <= 1'b0;
      acc_wr <= 1'b0;

      if (v2) begin
        acc     <= acc + alu_out;
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= cmd_opcode;
            len_q    <= cmd_len;
            d_base_q <= cmd_d_base;
            wr_addr  <= cmd_d_base;
            acc      <= '0;
            busy     <= 1'b1;
            if (cmd_is_vec && (cmd_len != '0)) begin
              state      <= S_RUN;
              mem_a_addr <= cmd_a_base;
              mem_b_addr <= cmd_b_base;
              rd_cnt     <= LEN_W'(1);
            end else begin
              // Zero-length, NOOP, STOP and unsupported opcodes finish at once.
              state <= S_DONE;
              done  <= 1'b1;
              err   <= cmd_is_bad;
              if (cmd_opcode == OP_STOP) halted <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (rd_cnt == len_q) begin
            state <= S_DRAIN;
          end else begin
            mem_a_addr <= mem_a_addr + ADDR_W'(1);
            mem_b_addr <= mem_b_addr + ADDR_W'(1);
            rd_cnt     <= rd_cnt + LEN_W'(1);
          end
        end

        S_DRAIN: begin
          // Last result is being captured when nothing follows it in the pipe.
          if (v2 && !v1) begin
            state  <= S_DONE;
            done   <= 1'b1;
            acc_wr <= op_is_dotp;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: BRAM and registered-ALU models around the DUT,
// with a scoreboard of expected result writes (address, data, cycle).

module tb_alu_issue_ctrl;

  localparam int OW = 4;
  localparam int AW = 10;
  localparam int LW = 11;

  localparam logic [OW-1:0] NOOP = 4'd0;
  localparam logic [OW-1:0] ADD  = 4'd1;
  localparam logic [OW-1:0] SUB  = 4'd2;
  localparam logic [OW-1:0] MUL  = 4'd3;
  localparam logic [OW-1:0] DOTP = 4'd4;
  localparam logic [OW-1:0] STOP = 4'd8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_opcode = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] cmd_a_base = '0;
  logic [AW-1:0] cmd_b_base = '0;
  logic [AW-1:0] cmd_d_base = '0;
  logic [AW-1:0] mem_a_addr;
  logic [31:0]   mem_a_data = '0;
  logic [AW-1:0] mem_b_addr;
  logic [31:0]   mem_b_data = '0;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [OW-1:0] alu_opcode;
  logic [31:0]   alu_out = '0;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [31:0]   res_data;
  logic          busy;
  logic          done;
  logic          halted;
  logic          err;

  alu_issue_ctrl #(.OPCODE_WIDTH(OW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_len    (cmd_len),
    .cmd_a_base (cmd_a_base),
    .cmd_b_base (cmd_b_base),
    .cmd_d_base (cmd_d_base),
    .mem_a_addr (mem_a_addr),
    .mem_a_data (mem_a_data),
    .mem_b_addr (mem_b_addr),
    .mem_b_data (mem_b_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .busy       (busy),
    .done       (done),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ALU behaviour: multiplier sees a[24:0] x b[17:0]; NOOP and others give 0.
  function automatic logic [31:0] alu_fn(input logic [OW-1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [42:0] p;
    p = {18'd0, a[24:0]} * {25'd0, b[17:0]};
    case (op)
      ADD:       return a + b;
      SUB:       return a - b;
      MUL, DOTP: return p[31:0];
      default:   return 32'd0;
    endcase
  endfunction

  logic [31:0] mem_a [0:(1<<AW)-1];
  logic [31:0] mem_b [0:(1<<AW)-1];

  // 1-cycle-latency BRAMs and the registered ALU.
  always @(posedge clk) begin
    mem_a_data <= mem_a[mem_a_addr];
    mem_b_data <= mem_b[mem_b_addr];
    alu_out    <= alu_fn(alu_opcode, alu_a, alu_b);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
    logic          with_done;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  acc_cyc = 0;

  // Scoreboard monitor: every result write must match the oldest expectation.
  always @(negedge clk) begin
    if (res_we) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'(res_we), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(res_addr), 32'(mon_e.addr));
        check("wr_data", res_data, mon_e.data);
        check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("wr_with_done", 32'(done), 32'(mon_e.with_done));
      end
    end
  end

  // Offer a command, wait for acceptance and queue up to nexp expected writes.
  task automatic issue(input logic [OW-1:0] op, input int len, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] d, input int nexp);
    bit          got;
    wr_t         e;
    logic [31:0] sum;
    logic [AW-1:0] ai, bi;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_len    = LW'(len);
    cmd_a_base = a;
    cmd_b_base = b;
    cmd_d_base = d;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("accept_timeout", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    if (op >= ADD && op <= DOTP && len > 0) begin
      sum = '0;
      for (int k = 0; k < len; k++) begin
        ai = a + AW'(k);
        bi = b + AW'(k);
        if (op == DOTP) begin
          sum = sum + alu_fn(op, mem_a[ai], mem_b[bi]);
        end else if (k < nexp) begin
          e.addr = d + AW'(k);
          e.data = alu_fn(op, mem_a[ai], mem_b[bi]);
          e.cyc = acc_cyc + 3 + k;
          e.with_done = 1'b0;
          sb.push_back(e);
        end
      end
      if (op == DOTP && nexp > 0) begin
        e.addr = d;
        e.data = sum;
        e.cyc = acc_cyc + len + 3;
        e.with_done = 1'b1;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    // Scramble the command fields; the DUT must have latched them.
    cmd_valid  = 1'b0;
    cmd_opcode = 4'hF;
    cmd_len    = LW'($urandom);
    cmd_a_base = AW'($urandom);
    cmd_b_base = AW'($urandom);
    cmd_d_base = AW'($urandom);
  endtask

  task automatic wait_done(input int lat, input logic exp_err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'(done), 32'd1);
    end else begin
      check("done_latency", 32'(cyc - acc_cyc), 32'(lat));
      check("err_at_done", 32'(err), 32'(exp_err));
      check("busy_at_done", 32'(busy), 32'd1);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_res_we"}, 32'(res_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_mem_a_addr", 32'(mem_a_addr), 32'd0);
    check("reset_mem_b_addr", 32'(mem_b_addr), 32'd0);
    rstn = 1'b1;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // 1. ADD N=4 -> 11,22,33,44 at 0x100..0x103, done at accept+7.
    for (int k = 0; k < 4; k++) begin
      mem_a[10'h010 + k] = 32'(k + 1);
      mem_b[10'h010 + k] = 32'((k + 1) * 10);
    end
    issue(ADD, 4, 10'h010, 10'h010, 10'h100, 4);
    wait_done(7, 1'b0);
    @(negedge clk);
    check_idle_zero("after_add");

    // 2. SUB N=2 with wrap-around results.
    mem_a[10'h020] = 32'd5; mem_a[10'h021] = 32'd0;
    mem_b[10'h020] = 32'd7; mem_b[10'h021] = 32'd1;
    issue(SUB, 2, 10'h020, 10'h020, 10'h140, 2);
    wait_done(5, 1'b0);

    // 3. DOTP N=3 -> single write 56 at 0x20 in the done cycle.
    mem_a[10'h030] = 32'd2; mem_a[10'h031] = 32'd3; mem_a[10'h032] = 32'd4;
    mem_b[10'h030] = 32'd5; mem_b[10'h031] = 32'd6; mem_b[10'h032] = 32'd7;
    issue(DOTP, 3, 10'h030, 10'h030, 10'h020, 1);
    wait_done(6, 1'b0);

    // 4. ADD across the top of the address space.
    issue(ADD, 4, 10'h3FE, 10'h050, 10'h3FF, 4);
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] ea;
      ea = 10'h3FE + AW'(k);
      @(negedge clk);
      check("rd_addr_a", 32'(mem_a_addr), 32'(ea));
    end
    wait_done(7, 1'b0);

    // Longer MUL and DOTP runs over random operands.
    issue(MUL, 6, 10'h200, 10'h280, 10'h300, 6);
    wait_done(9, 1'b0);
    issue(DOTP, 7, 10'h1F0, 10'h0A0, 10'h3A0, 1);
    wait_done(10, 1'b0);

    // 5a/5b. Zero-length vector, NOOP, unsupported opcodes.
    issue(MUL, 0, 10'h000, 10'h000, 10'h000, 0);
    wait_done(1, 1'b0);
    issue(NOOP, 5, 10'h000, 10'h000, 10'h000, 0);
    wait_done(1, 1'b0);
    issue(4'd6, 3, 10'h000, 10'h000, 10'h000, 0);
    wait_done(1, 1'b1);
    issue(4'd9, 3, 10'h000, 10'h000, 10'h000, 0);
    wait_done(1, 1'b1);
    @(negedge clk);
    check("err_one_cycle", 32'(err), 32'd0);

    // 6. Reset in the middle of ADD N=8: only elements 0 and 1 get written.
    issue(ADD, 8, 10'h060, 10'h060, 10'h180, 2);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("midreset");
    check("midreset_mem_a_addr", 32'(mem_a_addr), 32'd0);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midreset_sb_empty", 32'(sb.size()), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    issue(ADD, 3, 10'h070, 10'h070, 10'h1C0, 3);
    wait_done(6, 1'b0);

    // 5c. STOP -> halted, no further commands accepted until reset.
    issue(STOP, 0, 10'h000, 10'h000, 10'h000, 0);
    wait_done(1, 1'b0);
    check("stop_halted", 32'(halted), 32'd1);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = ADD;
    cmd_len    = LW'(2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("halted_cmd_ready", 32'(cmd_ready), 32'd0);
      check("halted_busy", 32'(busy), 32'd0);
    end
    cmd_valid = 1'b0;
    check("halted_sticky", 32'(halted), 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("halted_cleared", 32'(halted), 32'd0);
    rstn = 1'b1;
    #1;
    check("ready_after_unhalt", 32'(cmd_ready), 32'd1);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
